axi_note_bank: RTL and testbench

//   AXI4-Lite slave holding per-voice note state for NUM_VOICES synth voices.

---
 rtl/axi_note_bank.sv | 175 +++++++++++++++++
 tb/tb_axi_note_bank.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_note_bank.sv
// AXI4-Lite register bank holding note, velocity and gate for NUM_VOICES synth voices.
// Drives registered gate levels and one-cycle trigger pulses toward the voice oscillators.
module axi_note_bank #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_VOICES         = 8,
  parameter logic [31:0] ID_VALUE           = 32'h4E4F5445
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [7*NUM_VOICES-1:0]           voice_note,
  output logic [7*NUM_VOICES-1:0]           voice_vel,
  output logic [NUM_VOICES-1:0]             voice_gate,
  output logic [NUM_VOICES-1:0]             voice_trig
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(NUM_VOICES);
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_VOICES + 1);
  localparam logic [IDX_W-1:0] ID_IDX     = IDX_W'(NUM_VOICES + 2);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                   live;
  logic                   aw_held;
  logic                   w_held;
  logic [IDX_W-1:0]       aw_idx;
  logic [31:0]            w_data;
  logic [3:0]             w_strb;
  logic                   bvalid_r;
  logic [1:0]             bresp_r;
  logic                   rvalid_r;
  logic [31:0]            rdata_r;
  logic [1:0]             rresp_r;
  logic [6:0]             note_r [NUM_VOICES];
  logic [6:0]             vel_r  [NUM_VOICES];
  logic [NUM_VOICES-1:0]  gate_r;
  logic                   enable_r;
  logic [NUM_VOICES-1:0]  gate_eff;
  logic [NUM_VOICES-1:0]  gate_q;
  logic                   commit;
  logic [IDX_W-1:0]       ar_idx;
  logic [31:0]            rd_data;
  logic                   rd_err;
  logic                   unused_bits;

  // Ready lines stay low until the first edge after reset is released.
  assign S_AXI_AWREADY = live & ~aw_held;
  assign S_AXI_WREADY  = live & ~w_held;
  assign S_AXI_ARREADY = live & ~rvalid_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;

  assign commit   = aw_held & w_held & ~bvalid_r;
  assign ar_idx   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign gate_eff = gate_r & {NUM_VOICES{enable_r}};

  assign voice_gate = gate_eff;
  assign voice_trig = gate_eff & ~gate_q;

  assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_AWPROT, S_AXI_ARPROT,
                         w_data[31:17], w_data[15], w_data[7], w_strb[3]};

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7] = note_r[i];
      voice_vel[7*i +: 7]  = vel_r[i];
    end
  end

  // Write path: independent AW/W holding registers, one commit per B response.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      live     <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_r <= 1'b0;
      bresp_r  <= RESP_OKAY;
      gate_r   <= '0;
      enable_r <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= '0;
        vel_r[i]  <= '0;
      end
    end else begin
      live <= 1'b1;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_r <= 1'b1;
        bresp_r  <= (aw_idx > ID_IDX) ? RESP_SLVERR : RESP_OKAY;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (aw_idx == IDX_W'(i)) begin
            if (w_strb[0]) note_r[i] <= w_data[6:0];
            if (w_strb[1]) vel_r[i]  <= w_data[14:8];
            if (w_strb[2]) gate_r[i] <= w_data[16];
          end
        end
        if (aw_idx == CTRL_IDX && w_strb[0]) begin
          enable_r <= w_data[0];
          if (w_data[1]) gate_r <= '0;
        end
      end else if (bvalid_r && S_AXI_BREADY) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Read mux sees register state before any same-cycle commit lands.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (ar_idx == IDX_W'(i)) rd_data = {15'b0, gate_r[i], 1'b0, vel_r[i], 1'b0, note_r[i]};
    end
    if (ar_idx == CTRL_IDX)        rd_data = {31'b0, enable_r};
    else if (ar_idx == STATUS_IDX) rd_data = 32'(gate_eff);
    else if (ar_idx == ID_IDX)     rd_data = ID_VALUE;
    else if (ar_idx > ID_IDX)      rd_err  = 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
      rresp_r  <= RESP_OKAY;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data;
      rresp_r  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_r && S_AXI_RREADY) begin
      rvalid_r <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) gate_q <= '0;
    else                gate_q <= gate_eff;
  end

endmodule

// File: tb/tb_axi_note_bank.sv
// Self-checking bench for axi_note_bank: table-driven AXI transactions with a response
// scoreboard, plus hand-written sequences for split handshakes, triggers and reset.
module tb_axi_note_bank;
  localparam int NV = 8;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [31:0] ID = 32'h4E4F5445;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [7*NV-1:0] voice_note, voice_vel;
  logic [NV-1:0] voice_gate, voice_trig;

  always #5 clk = ~clk;

  axi_note_bank #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_VOICES(NV),
                  .ID_VALUE(ID)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .voice_note(voice_note), .voice_vel(voice_vel), .voice_gate(voice_gate), .voice_trig(voice_trig)
  );

  typedef struct {
    bit          is_write;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    string       name;
  } vec_t;

  typedef struct {
    bit          is_write;
    logic [31:0] data;
    logic [1:0]  resp;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int trig_count [NV] = '{default: 0};

  always @(negedge clk) begin
    for (int i = 0; i < NV; i++) if (voice_trig[i] === 1'b1) trig_count[i]++;
  end

  function automatic vec_t mk(bit w, logic [5:0] a, logic [31:0] d, logic [3:0] s,
                              logic [31:0] ed, logic [1:0] er, string n);
    vec_t v;
    v.is_write = w; v.addr = a; v.data = d; v.strb = s;
    v.exp_data = ed; v.exp_resp = er; v.name = n;
    return v;
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL timeout_%s: no handshake within cycle budget", name);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_exp(input bit w, input logic [31:0] d, input logic [1:0] r, input string n);
    exp_t e;
    e.is_write = w; e.data = d; e.resp = r; e.name = n;
    sb.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: response data=%h resp=%0d with nothing expected", d, r);
      return;
    end
    e = sb.pop_front();
    if (r !== e.resp || (!e.is_write && d !== e.data)) begin
      errors++;
      $display("[TB] FAIL %s: got data=%h resp=%0d, expected data=%h resp=%0d",
               e.name, d, r, e.data, e.resp);
    end
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    resp = 2'b11;
    awaddr = addr; awvalid = 1; wdata = data; wstrb = strb; wvalid = 1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk); #1; n++;
      if (aw_hs) begin awvalid = 0; aw_done = 1; end
      if (w_hs) begin wvalid = 0; w_done = 1; end
    end
    if (!(aw_done && w_done)) begin
      awvalid = 0; wvalid = 0;
      note_timeout("aw_w");
      return;
    end
    bready = 1; n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin bready = 0; note_timeout("bvalid"); return; end
    resp = bresp;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_hs = 0;
    int n = 0;
    data = 'x; resp = 2'b11;
    araddr = addr; arvalid = 1;
    while (!ar_hs && n < 50) begin
      ar_hs = arready;
      @(posedge clk); #1; n++;
    end
    arvalid = 0;
    if (!ar_hs) begin note_timeout("ar"); return; end
    rready = 1; n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin rready = 0; note_timeout("rvalid"); return; end
    data = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [31:0] d;
    logic [1:0] r;
    push_exp(v.is_write, v.exp_data, v.exp_resp, v.name);
    if (v.is_write) begin axi_write(v.addr, v.data, v.strb, r); d = '0; end
    else axi_read(v.addr, d, r);
    check_output(d, r);
  endtask

  // Address and data offered on separate cycles, with BREADY held low for 10 cycles.
  task automatic split_write(input bit aw_first, input logic [5:0] addr, input logic [31:0] data,
                             input string name);
    int busy = 0, bad = 0, n = 0, extra = 0;
    logic [1:0] b_first;
    push_exp(1, '0, OKAY, name);
    if (aw_first) begin awaddr = addr; awvalid = 1; end
    else begin wdata = data; wstrb = 4'hF; wvalid = 1; end
    check_val({name, "_first_ready"}, aw_first ? awready : wready, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    repeat (5) begin
      if (aw_first ? awready : wready) busy++;
      if (bvalid) busy++;
      @(posedge clk); #1;
    end
    check_val({name, "_held_not_ready"}, busy, 0);
    if (aw_first) begin wdata = data; wstrb = 4'hF; wvalid = 1; end
    else begin awaddr = addr; awvalid = 1; end
    check_val({name, "_second_ready"}, aw_first ? wready : awready, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin note_timeout(name); return; end
    b_first = bresp;
    repeat (10) begin
      @(posedge clk); #1;
      if (!bvalid || bresp !== b_first) bad++;
    end
    check_val({name, "_bvalid_held"}, bad, 0);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check_output('0, b_first);
    repeat (5) begin
      if (bvalid) extra++;
      @(posedge clk); #1;
    end
    check_val({name, "_single_commit"}, extra, 0);
  endtask

  initial begin
    $display("[TB] axi_note_bank bench start");
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_ready_valid", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    check_val("reset_outputs", {voice_gate, voice_trig, voice_note[31:0]}, 0);
    rst_n = 1;
    idle(2);

    for (int i = 0; i < NV; i++) vecs.push_back(mk(0, 6'(4*i), 0, 0, 0, OKAY, $sformatf("rst_voice%0d", i)));
    vecs.push_back(mk(0, 6'd32, 0, 0, 0, OKAY, "rst_ctrl"));
    vecs.push_back(mk(0, 6'd36, 0, 0, 0, OKAY, "rst_status"));
    vecs.push_back(mk(0, 6'd40, 0, 0, ID, OKAY, "id"));
    vecs.push_back(mk(1, 6'd32, 32'h1, 4'hF, 0, OKAY, "wr_ctrl_en"));
    vecs.push_back(mk(1, 6'd12, 32'h0001_3C45, 4'hF, 0, OKAY, "wr_voice3"));
    vecs.push_back(mk(0, 6'd12, 0, 0, 32'h0001_3C45, OKAY, "rd_voice3"));
    vecs.push_back(mk(0, 6'd36, 0, 0, 32'h08, OKAY, "status_v3"));
    vecs.push_back(mk(1, 6'd12, 32'hFFFF_FF10, 4'b0001, 0, OKAY, "wr_voice3_lane0"));
    vecs.push_back(mk(0, 6'd15, 0, 0, 32'h0001_3C10, OKAY, "rd_voice3_lane0"));
    vecs.push_back(mk(0, 6'd44, 0, 0, 0, SLVERR, "rd_unmapped"));
    vecs.push_back(mk(0, 6'd60, 0, 0, 0, SLVERR, "rd_top_word"));
    vecs.push_back(mk(1, 6'd44, 32'hFFFF_FFFF, 4'hF, 0, SLVERR, "wr_unmapped"));
    vecs.push_back(mk(0, 6'd12, 0, 0, 32'h0001_3C10, OKAY, "voice3_after_slverr"));
    vecs.push_back(mk(0, 6'd32, 0, 0, 32'h1, OKAY, "ctrl_after_slverr"));
    vecs.push_back(mk(1, 6'd36, 32'hFFFF_FFFF, 4'hF, 0, OKAY, "wr_status_ro"));
    vecs.push_back(mk(1, 6'd40, 32'h0, 4'hF, 0, OKAY, "wr_id_ro"));
    vecs.push_back(mk(0, 6'd40, 0, 0, ID, OKAY, "id_after_wr"));
    vecs.push_back(mk(0, 6'd36, 0, 0, 32'h08, OKAY, "status_after_ro_wr"));
    foreach (vecs[i]) apply_stimulus(vecs[i]);

    idle(2);
    check_val("note3", voice_note[27:21], 7'h10);
    check_val("vel3", voice_vel[27:21], 7'h3C);
    check_val("gate_vec", voice_gate, 8'h08);
    check_val("trig3_count", trig_count[3], 1);
    check_val("trig_others", trig_count[0] + trig_count[1] + trig_count[2] + trig_count[4] +
              trig_count[5] + trig_count[6] + trig_count[7], 0);

    split_write(1, 6'd4, 32'h0000_2A11, "aw_first");
    split_write(0, 6'd8, 32'h0000_3322, "w_first");
    check_val("note1", voice_note[13:7], 7'h11);
    check_val("vel1", voice_vel[13:7], 7'h2A);
    check_val("note2", voice_note[20:14], 7'h22);
    check_val("vel2", voice_vel[20:14], 7'h33);

    apply_stimulus(mk(1, 6'd0, 32'h0001_0000, 4'hF, 0, OKAY, "gate_v0"));
    apply_stimulus(mk(1, 6'd20, 32'h0001_0000, 4'hF, 0, OKAY, "gate_v5"));
    apply_stimulus(mk(1, 6'd28, 32'h0001_0000, 4'hF, 0, OKAY, "gate_v7"));
    idle(2);
    check_val("trig_0_5_7", {trig_count[0][3:0], trig_count[5][3:0], trig_count[7][3:0]}, 12'h111);
    apply_stimulus(mk(0, 6'd36, 0, 0, 32'hA9, OKAY, "status_four_gates"));
    apply_stimulus(mk(1, 6'd32, 32'h3, 4'hF, 0, OKAY, "all_off"));
    apply_stimulus(mk(0, 6'd36, 0, 0, 0, OKAY, "status_after_all_off"));
    apply_stimulus(mk(0, 6'd32, 0, 0, 32'h1, OKAY, "ctrl_all_off_reads0"));
    apply_stimulus(mk(0, 6'd12, 0, 0, 32'h0000_3C10, OKAY, "voice3_kept_note_vel"));
    apply_stimulus(mk(1, 6'd32, 32'h1, 4'hF, 0, OKAY, "reenable"));
    idle(2);
    check_val("no_trig_after_all_off", {trig_count[0][3:0], trig_count[3][3:0], trig_count[5][3:0],
              trig_count[7][3:0]}, 16'h1111);
    apply_stimulus(mk(0, 6'd36, 0, 0, 0, OKAY, "status_still_clear"));

    apply_stimulus(mk(1, 6'd32, 32'h0, 4'hF, 0, OKAY, "disable"));
    apply_stimulus(mk(1, 6'd24, 32'h0001_0000, 4'hF, 0, OKAY, "gate_v6_disabled"));
    apply_stimulus(mk(0, 6'd36, 0, 0, 0, OKAY, "status_disabled"));
    apply_stimulus(mk(1, 6'd32, 32'h1, 4'hF, 0, OKAY, "enable_rise"));
    idle(2);
    check_val("trig6_on_enable", trig_count[6], 1);
    apply_stimulus(mk(0, 6'd36, 0, 0, 32'h40, OKAY, "status_v6"));
    apply_stimulus(mk(1, 6'd32, 32'h0, 4'hF, 0, OKAY, "enable_fall"));
    idle(2);
    check_val("gate_drop_on_disable", voice_gate, 8'h00);
    apply_stimulus(mk(1, 6'd32, 32'h1, 4'hF, 0, OKAY, "enable_rise2"));
    apply_stimulus(mk(1, 6'd24, 32'h0001_0000, 4'hF, 0, OKAY, "gate_v6_rewrite"));
    idle(2);
    check_val("trig6_no_retrigger", trig_count[6], 2);

    awaddr = 6'd0; wdata = 32'h0001_007F; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    rst_n = 0;
    #1;
    check_val("midreset_bvalid", bvalid, 0);
    check_val("midreset_outputs", {voice_gate, voice_note}, 0);
    check_val("midreset_vel", voice_vel, 0);
    idle(3);
    rst_n = 1;
    idle(4);
    check_val("post_reset_no_b", bvalid, 0);
    apply_stimulus(mk(0, 6'd0, 0, 0, 0, OKAY, "voice0_after_reset"));
    apply_stimulus(mk(0, 6'd12, 0, 0, 0, OKAY, "voice3_after_reset"));
    apply_stimulus(mk(0, 6'd32, 0, 0, 0, OKAY, "ctrl_after_reset"));
    check_val("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
